// File: rtl/reg_bus_pkg.sv
// Shared register-bus definitions: bridge state encoding and the
// default geometry used by the bridge, register FSM and bank.
package reg_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RELEASE,
        ST_RESP
    } bus_state_e;

    localparam int DEF_NUM_OF_REG = 4;
    localparam int DEF_ADDR_W     = 8;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_TIMEOUT    = 16;

endpackage

// File: rtl/reg_host_bridge_if.sv
// Host request/response channels of the register bridge.
// master = host side, slave = bridge side.
interface reg_host_bridge_if
    import reg_bus_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              host_req_valid;
    logic              host_req_ready;
    logic              host_req_wr;
    logic [ADDR_W-1:0] host_req_addr;
    logic [DATA_W-1:0] host_req_wdata;
    logic              host_rsp_valid;
    logic              host_rsp_ready;
    logic [DATA_W-1:0] host_rsp_rdata;
    logic              host_rsp_err;

    modport master (
        output host_req_valid,
        output host_req_wr,
        output host_req_addr,
        output host_req_wdata,
        output host_rsp_ready,
        input  host_req_ready,
        input  host_rsp_valid,
        input  host_rsp_rdata,
        input  host_rsp_err
    );

    modport slave (
        input  host_req_valid,
        input  host_req_wr,
        input  host_req_addr,
        input  host_req_wdata,
        input  host_rsp_ready,
        output host_req_ready,
        output host_rsp_valid,
        output host_rsp_rdata,
        output host_rsp_err
    );

endinterface

// File: rtl/reg_bus_timer.sv
// Loadable up-counter guarding ack waits; expired marks the
// last cycle the bridge is allowed to keep waiting.
module reg_bus_timer
    import reg_bus_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/reg_host_bridge.sv
// Host front end for the register-access FSM: one request at a
// time, range check, ack handshake with timeout, registered response.
module reg_host_bridge
    import reg_bus_pkg::*;
#(
    parameter int NUM_OF_REG = DEF_NUM_OF_REG,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    reg_host_bridge_if.slave  host,
    output logic              sel_en,
    output logic              wr_rd_s,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              ack,
    input  logic [DATA_W-1:0] rd_data
);

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(NUM_OF_REG);

    bus_state_e        state_q;
    bus_state_e        state_d;
    logic              sel_d;
    logic              wr_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;
    logic              vld_d;
    logic [DATA_W-1:0] rdata_d;
    logic              err_d;
    logic              tmr_clr;
    logic              tmr_en;
    logic              tmr_exp;
    logic              out_of_range;

    assign out_of_range = ({1'b0, host.host_req_addr} >= LIMIT);
    assign host.host_req_ready = (state_q == ST_IDLE);

    reg_bus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_exp)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_en;
        wr_d    = wr_rd_s;
        addr_d  = addr;
        wdata_d = wr_data;
        vld_d   = host.host_rsp_valid;
        rdata_d = host.host_rsp_rdata;
        err_d   = host.host_rsp_err;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                tmr_clr = 1'b1;
                if (host.host_req_valid) begin
                    if (out_of_range) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        vld_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        sel_d   = 1'b1;
                        wr_d    = host.host_req_wr;
                        addr_d  = host.host_req_addr;
                        wdata_d = host.host_req_wdata;
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (ack) begin
                    rdata_d = wr_rd_s ? '0 : rd_data;
                    err_d   = 1'b0;
                    sel_d   = 1'b0;
                    tmr_clr = 1'b1;
                    state_d = ST_RELEASE;
                end else if (tmr_exp) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    sel_d   = 1'b0;
                    tmr_clr = 1'b1;
                    state_d = ST_RELEASE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            // wait for ack to drop so it cannot complete the next access
            ST_RELEASE: begin
                if (!ack) begin
                    vld_d   = 1'b1;
                    state_d = ST_RESP;
                end else if (tmr_exp) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    vld_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_RESP: begin
                if (host.host_rsp_ready) begin
                    vld_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q             <= ST_IDLE;
            sel_en              <= 1'b0;
            wr_rd_s             <= 1'b0;
            addr                <= '0;
            wr_data             <= '0;
            host.host_rsp_valid <= 1'b0;
            host.host_rsp_rdata <= '0;
            host.host_rsp_err   <= 1'b0;
        end else begin
            state_q             <= state_d;
            sel_en              <= sel_d;
            wr_rd_s             <= wr_d;
            addr                <= addr_d;
            wr_data             <= wdata_d;
            host.host_rsp_valid <= vld_d;
            host.host_rsp_rdata <= rdata_d;
            host.host_rsp_err   <= err_d;
        end
    end

endmodule

// File: tb/tb_reg_host_bridge.sv
// Bench for reg_host_bridge paired with a zero-wait register FSM
// and 4-entry bank; responses checked against a transaction model.
module tb_reg_host_bridge;

    logic       clk;
    logic       rst_n;
    logic       sel_en;
    logic       wr_rd_s;
    logic [7:0] addr;
    logic [7:0] wr_data;
    logic       ack;
    logic [7:0] rd_data;
    logic [7:0] bank [4];
    logic [3:0] wr_en;
    logic       ack_tie0;

    logic [7:0] ref_mem [4];
    int checks;
    int failures;

    reg_host_bridge_if hif ();

    reg_host_bridge dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .host    (hif.slave),
        .sel_en  (sel_en),
        .wr_rd_s (wr_rd_s),
        .addr    (addr),
        .wr_data (wr_data),
        .ack     (ack),
        .rd_data (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // register FSM + bank: ack one cycle after sel_en, drop after sel_en falls
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack     <= 1'b0;
            rd_data <= '0;
            wr_en   <= '0;
        end else begin
            wr_en <= '0;
            if (sel_en && !ack && !ack_tie0) begin
                ack <= 1'b1;
                if (wr_rd_s) begin
                    bank[addr[1:0]]  <= wr_data;
                    wr_en[addr[1:0]] <= 1'b1;
                end else begin
                    rd_data <= bank[addr[1:0]];
                end
            end else if (!sel_en) begin
                ack <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic wr, input logic [7:0] a,
                        input logic [7:0] d, input string tag,
                        output int waited);
        logic       oor;
        logic       tmo;
        logic       exp_err;
        logic [7:0] exp_rd;
        int         exp_lat;
        int         exp_sel;
        int         lat;
        int         seln;
        oor     = (a >= 8'd4);
        tmo     = !oor && ack_tie0;
        exp_err = oor || tmo;
        exp_rd  = (oor || tmo || wr) ? 8'h00 : ref_mem[a[1:0]];
        exp_lat = oor ? 0 : (tmo ? 17 : 4);
        exp_sel = oor ? 0 : (tmo ? 16 : 2);
        if (!oor && !tmo && wr) ref_mem[a[1:0]] = d;

        @(negedge clk);
        hif.host_req_valid = 1'b1;
        hif.host_req_wr    = wr;
        hif.host_req_addr  = a;
        hif.host_req_wdata = d;
        waited = 0;
        while (!hif.host_req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_accept"}, 32'(waited < 50), 32'd1);
        @(posedge clk);
        #1;
        hif.host_req_valid = 1'b0;
        lat  = 0;
        seln = 0;
        while (1) begin
            if (sel_en) begin
                seln++;
                chk({tag, "_bus_wr"}, 32'(wr_rd_s), 32'(wr));
                chk({tag, "_bus_addr"}, 32'(addr), 32'(a));
            end
            if (hif.host_rsp_valid || lat >= 100) break;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_sel_cycles"}, 32'(seln), 32'(exp_sel));
        chk({tag, "_err"}, 32'(hif.host_rsp_err), 32'(exp_err));
        chk({tag, "_rdata"}, 32'(hif.host_rsp_rdata), 32'(exp_rd));
        if (hif.host_rsp_ready) begin
            @(posedge clk);
            #1;
            chk({tag, "_rsp_done"}, 32'(hif.host_rsp_valid), 32'd0);
            chk({tag, "_idle"}, 32'(hif.host_req_ready), 32'd1);
        end
    endtask

    initial begin
        int         w;
        int         w2;
        logic [7:0] cap_rd;
        logic       cap_err;
        int         seen;

        checks   = 0;
        failures = 0;
        ack_tie0 = 1'b0;
        hif.host_req_valid = 1'b0;
        hif.host_req_wr    = 1'b0;
        hif.host_req_addr  = '0;
        hif.host_req_wdata = '0;
        hif.host_rsp_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(hif.host_req_ready), 32'd1);
        chk("rst_sel_en", 32'(sel_en), 32'd0);
        chk("rst_rsp_valid", 32'(hif.host_rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(hif.host_rsp_err), 32'd0);
        chk("rst_rsp_rdata", 32'(hif.host_rsp_rdata), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        send(1'b1, 8'd2, 8'hA5, "t1_wr2", w);
        chk("t1_bank2", 32'(bank[2]), 32'hA5);
        send(1'b1, 8'd1, 8'h3C, "init_wr1", w);
        send(1'b1, 8'd0, 8'($urandom), "init_wr0", w);
        send(1'b1, 8'd3, 8'($urandom), "init_wr3", w);
        send(1'b0, 8'd2, 8'h00, "t1_rd2", w);

        hif.host_rsp_ready = 1'b0;
        send(1'b0, 8'd1, 8'h00, "t2_rd1", w);
        w2 = 0;
        fork
            send(1'b0, 8'd3, 8'h00, "t2_rd3", w2);
            begin
                repeat (3) @(negedge clk);
                hif.host_rsp_ready = 1'b1;
            end
        join
        chk("t2_held_off", 32'(w2 >= 3), 32'd1);

        send(1'b0, 8'd4, 8'h00, "t3_rd4", w);
        send(1'b1, 8'd5, 8'h77, "t3_wr5", w);
        send(1'b0, 8'hFF, 8'h00, "t3_rdff", w);

        ack_tie0 = 1'b1;
        send(1'b0, 8'd1, 8'h00, "t4_tmo", w);
        ack_tie0 = 1'b0;
        send(1'b0, 8'd1, 8'h00, "t4_after", w);

        hif.host_rsp_ready = 1'b0;
        send(1'b0, 8'd2, 8'h00, "t5_rd2", w);
        cap_rd  = hif.host_rsp_rdata;
        cap_err = hif.host_rsp_err;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("t5_valid", 32'(hif.host_rsp_valid), 32'd1);
            chk("t5_rdata", 32'(hif.host_rsp_rdata), 32'(cap_rd));
            chk("t5_err", 32'(hif.host_rsp_err), 32'(cap_err));
            chk("t5_req_ready", 32'(hif.host_req_ready), 32'd0);
        end
        @(negedge clk);
        hif.host_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_idle", 32'(hif.host_req_ready), 32'd1);
        chk("t5_valid_low", 32'(hif.host_rsp_valid), 32'd0);

        ack_tie0 = 1'b1;
        @(negedge clk);
        hif.host_req_valid = 1'b1;
        hif.host_req_wr    = 1'b1;
        hif.host_req_addr  = 8'd0;
        hif.host_req_wdata = 8'h5A;
        @(posedge clk);
        #1;
        hif.host_req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_in_access", 32'(sel_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_sel_async", 32'(sel_en), 32'd0);
        chk("t6_valid_async", 32'(hif.host_rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ack_tie0 = 1'b0;
        chk("t6_req_ready", 32'(hif.host_req_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (hif.host_rsp_valid || sel_en) seen++;
        end
        chk("t6_no_response", 32'(seen), 32'd0);

        for (int i = 0; i < 24; i++) begin
            send(1'($urandom), 8'($urandom_range(0, 5)),
                 8'($urandom), "rand", w);
        end
        for (int i = 0; i < 4; i++) begin
            send(1'b0, 8'(i), 8'h00, "final_rd", w);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
